// File: rtl/traffic_node.sv
// Processing-element model for a switch local port: injects PACKETS_NUM flits with
// round-robin destinations and sinks delivered flits while keeping saturating statistics.
module traffic_node #(
    parameter int DATA_SIZE   = 32,
    parameter int ADDR_SIZE   = 4,
    parameter int NODES_NUM   = 9,
    parameter int ADDR        = 0,
    parameter int PACKETS_NUM = 16,
    parameter int GEN_PERIOD  = 4,
    parameter int CNT_SIZE    = 16,
    parameter int BUS_SIZE    = DATA_SIZE + ADDR_SIZE + 1
) (
    input  logic                clk,
    input  logic                a_rst,
    input  logic                r_ready_in,
    output logic                wr_ready_out,
    output logic [BUS_SIZE-1:0] data_o,
    input  logic                wr_ready_in,
    output logic                r_ready_out,
    input  logic [BUS_SIZE-1:0] data_i,
    output logic [CNT_SIZE-1:0] sent_cnt,
    output logic [CNT_SIZE-1:0] recv_cnt,
    output logic [CNT_SIZE-1:0] err_cnt,
    output logic                done
);

    localparam int SEQ_SIZE = DATA_SIZE - ADDR_SIZE;
    localparam int PER_W    = $clog2(GEN_PERIOD + 1) + 1;
    localparam int TX_W     = $clog2(PACKETS_NUM + 1) + 1;
    localparam logic [CNT_SIZE-1:0]  CNT_MAX = '1;
    localparam logic [ADDR_SIZE-1:0] SELF    = ADDR_SIZE'(ADDR);
    localparam logic [ADDR_SIZE-1:0] DEST0   = ADDR_SIZE'((ADDR + 1) % NODES_NUM);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } tx_state_t;

    tx_state_t             state;
    logic [PER_W-1:0]      period_cnt;
    logic [TX_W-1:0]       tx_num;
    logic [SEQ_SIZE-1:0]   seq;
    logic [ADDR_SIZE-1:0]  dest;
    logic                  rx_bad;
    logic                  rx_payload_unused;

    function automatic logic [ADDR_SIZE-1:0] next_dest(input logic [ADDR_SIZE-1:0] d);
        int n;
        n = (int'(d) + 1) % NODES_NUM;
        if (n == ADDR)
            n = (n + 1) % NODES_NUM;
        return ADDR_SIZE'(n);
    endfunction

    function automatic logic [BUS_SIZE-1:0] make_flit(input logic [ADDR_SIZE-1:0] d,
                                                      input logic [SEQ_SIZE-1:0]  s);
        return {1'b1, d, SELF, s};
    endfunction

    // tx_num tracks completion separately because sent_cnt may saturate below PACKETS_NUM
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state        <= ST_WAIT;
            period_cnt   <= '0;
            tx_num       <= '0;
            seq          <= '0;
            dest         <= DEST0;
            wr_ready_out <= 1'b0;
            data_o       <= '0;
            sent_cnt     <= '0;
            done         <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (PACKETS_NUM == 0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (period_cnt >= PER_W'(GEN_PERIOD)) begin
                        state        <= ST_SEND;
                        wr_ready_out <= 1'b1;
                        data_o       <= make_flit(dest, seq);
                        period_cnt   <= '0;
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (r_ready_in) begin
                        if (sent_cnt != CNT_MAX)
                            sent_cnt <= sent_cnt + 1'b1;
                        seq    <= seq + 1'b1;
                        dest   <= next_dest(dest);
                        tx_num <= tx_num + 1'b1;
                        if (tx_num == TX_W'(PACKETS_NUM - 1)) begin
                            state        <= ST_DONE;
                            wr_ready_out <= 1'b0;
                            done         <= 1'b1;
                        end else if (GEN_PERIOD == 0) begin
                            data_o <= make_flit(next_dest(dest), seq + 1'b1);
                        end else begin
                            // the acceptance cycle itself counts as the first idle cycle
                            state        <= ST_WAIT;
                            wr_ready_out <= 1'b0;
                            period_cnt   <= PER_W'(1);
                        end
                    end
                end
                ST_DONE: ;
                default: state <= ST_WAIT;
            endcase
        end
    end

    assign rx_bad            = !data_i[BUS_SIZE-1] || (data_i[BUS_SIZE-2:DATA_SIZE] != SELF);
    assign rx_payload_unused = ^data_i[DATA_SIZE-1:0];

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_ready_out <= 1'b0;
            recv_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            r_ready_out <= 1'b1;
            if (wr_ready_in && r_ready_out) begin
                if (recv_cnt != CNT_MAX)
                    recv_cnt <= recv_cnt + 1'b1;
                if (rx_bad && err_cnt != CNT_MAX)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_node.sv
// Randomized bench for traffic_node: two instances checked each cycle against a
// timing/count model derived from the flit schedule rather than from any state machine.
module tb_traffic_node;

    localparam int BUS = 37;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           rin [2];
    logic           win [2];
    logic [BUS-1:0] din [2];

    logic           wr0, wr1, rr0, rr1, done0, done1;
    logic [BUS-1:0] data0, data1;
    logic [15:0]    sent0, recv0, err0;
    logic [1:0]     sent1, recv1, err1;

    traffic_node #(.DATA_SIZE(32), .ADDR_SIZE(4), .NODES_NUM(4), .ADDR(0),
                   .PACKETS_NUM(3), .GEN_PERIOD(2), .CNT_SIZE(16)) dut0 (
        .clk(clk), .a_rst(rst), .r_ready_in(rin[0]), .wr_ready_out(wr0), .data_o(data0),
        .wr_ready_in(win[0]), .r_ready_out(rr0), .data_i(din[0]),
        .sent_cnt(sent0), .recv_cnt(recv0), .err_cnt(err0), .done(done0));

    traffic_node #(.DATA_SIZE(32), .ADDR_SIZE(4), .NODES_NUM(3), .ADDR(2),
                   .PACKETS_NUM(4), .GEN_PERIOD(0), .CNT_SIZE(2)) dut1 (
        .clk(clk), .a_rst(rst), .r_ready_in(rin[1]), .wr_ready_out(wr1), .data_o(data1),
        .wr_ready_in(win[1]), .r_ready_out(rr1), .data_i(din[1]),
        .sent_cnt(sent1), .recv_cnt(recv1), .err_cnt(err1), .done(done1));

    int vectors = 0;
    int miscompares = 0;

    // model: edges since reset release, flits accepted, edge at which next flit appears
    int e;
    int n_sent [2];
    int rise   [2];
    int recv   [2];
    int err    [2];
    bit ew     [2];
    int hold0;
    int rx_plan [$];

    function automatic int p_addr(int i);  return (i == 0) ? 0 : 2;     endfunction
    function automatic int p_nodes(int i); return (i == 0) ? 4 : 3;     endfunction
    function automatic int p_pkts(int i);  return (i == 0) ? 3 : 4;     endfunction
    function automatic int p_gen(int i);   return (i == 0) ? 2 : 0;     endfunction
    function automatic int p_cmax(int i);  return (i == 0) ? 65535 : 3; endfunction
    function automatic int sat(int v, int m); return (v > m) ? m : v;   endfunction

    function automatic logic [BUS-1:0] exp_flit(int i, int k);
        int d;
        d = (p_addr(i) + 1 + (k % (p_nodes(i) - 1))) % p_nodes(i);
        return {1'b1, 4'(d), 4'(p_addr(i)), 28'(k)};
    endfunction

    function automatic logic [BUS-1:0] gen_flit(int i, int kind);
        logic [27:0] pay;
        pay = 28'($urandom);
        case (kind)
            0:       return {1'b1, 4'(p_addr(i)), 4'($urandom), pay};
            1:       return {1'b1, 4'((p_addr(i) + 1 + int'($urandom_range(0, 14))) % 16),
                             4'($urandom), pay};
            default: return {1'b0, 4'($urandom), 4'($urandom), pay};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e = 0;
        for (int i = 0; i < 2; i++) begin
            n_sent[i] = 0;
            rise[i]   = p_gen(i) + 1;
            recv[i]   = 0;
            err[i]    = 0;
        end
    endtask

    task automatic step(input bit hold_rst);
        int kind [2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic           a_wr, a_rr, a_done;
            logic [BUS-1:0] a_data;
            logic [15:0]    a_sent, a_recv, a_err;
            a_wr   = (i == 0) ? wr0 : wr1;
            a_rr   = (i == 0) ? rr0 : rr1;
            a_done = (i == 0) ? done0 : done1;
            a_data = (i == 0) ? data0 : data1;
            a_sent = (i == 0) ? sent0 : {14'd0, sent1};
            a_recv = (i == 0) ? recv0 : {14'd0, recv1};
            a_err  = (i == 0) ? err0  : {14'd0, err1};
            ew[i] = !rst && (n_sent[i] < p_pkts(i)) && (e >= rise[i]);
            check($sformatf("dut%0d.wr_ready", i), 64'(a_wr), 64'(ew[i]));
            if (rst)
                check($sformatf("dut%0d.data_rst", i), 64'(a_data), 64'd0);
            else if (ew[i])
                check($sformatf("dut%0d.data", i), 64'(a_data), 64'(exp_flit(i, n_sent[i])));
            check($sformatf("dut%0d.r_ready", i), 64'(a_rr), 64'(!rst && e >= 1));
            check($sformatf("dut%0d.sent_cnt", i), 64'(a_sent), 64'(sat(n_sent[i], p_cmax(i))));
            check($sformatf("dut%0d.recv_cnt", i), 64'(a_recv), 64'(sat(recv[i], p_cmax(i))));
            check($sformatf("dut%0d.err_cnt", i), 64'(a_err), 64'(sat(err[i], p_cmax(i))));
            check($sformatf("dut%0d.done", i), 64'(a_done),
                  64'(!rst && e >= 1 && n_sent[i] >= p_pkts(i)));
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 0 && ew[0] && hold0 > 0) begin
                rin[0] = 1'b0;
                hold0--;
            end else begin
                rin[i] = ($urandom_range(0, 3) != 0);
            end
            if (i == 0 && e >= 1 && !rst && rx_plan.size() > 0) begin
                win[0]  = 1'b1;
                kind[0] = rx_plan.pop_front();
            end else begin
                win[i]  = ($urandom_range(0, 1) == 1);
                kind[i] = int'($urandom_range(0, 2));
            end
            din[i] = gen_flit(i, kind[i]);
        end
        rst = hold_rst;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (ew[i] && rin[i]) begin
                    n_sent[i]++;
                    rise[i] = e + 1 + p_gen(i);
                end
                if (e >= 1 && win[i]) begin
                    recv[i]++;
                    if (kind[i] != 0)
                        err[i]++;
                end
            end
            e++;
        end
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 2; i++) begin
            rin[i] = 1'b0;
            win[i] = 1'b0;
            din[i] = '0;
        end
        model_reset();
        hold0 = 10;
        rx_plan = '{0, 0, 0, 1, 2};
        step(1'b1);
        step(1'b1);
        repeat (80) step(1'b0);

        // asynchronous reset while dut0 is presenting its second flit
        model_reset();
        rst = 1'b1;
        repeat (2) step(1'b1);
        guard = 0;
        while (!(n_sent[0] == 1 && ew[0] && !rin[0]) && guard < 300) begin
            step(1'b0);
            guard++;
        end
        check("reach_mid_send", 64'(guard < 300), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst.wr_ready", 64'(wr0), 64'd0);
        check("async_rst.data", 64'(data0), 64'd0);
        check("async_rst.sent_cnt", 64'(sent0), 64'd0);
        check("async_rst.r_ready", 64'(rr0), 64'd0);
        model_reset();
        repeat (2) step(1'b1);
        repeat (200) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
